// File: rtl/bus_reg_pkg.sv
// Shared types and default sizes for the bus register slave.
// Holds the FSM state enum, default geometry and counter width.
package bus_reg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 12;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/bus_reg_slave_if.sv
// Request/response bus between a master and the register slave.
// Signals: req_valid/ready/write/addr/wdata, rsp_valid/ready/rdata/err.
interface bus_reg_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/bus_reg_file.sv
// Register storage: one sync write port, one combinational read port.
// Ports: clock, reset, wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module bus_reg_file
    import bus_reg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    // Addresses at or beyond DEPTH never touch storage.
    assign wr_ok = ({1'b0, wr_addr} < LIMIT);
    assign rd_ok = ({1'b0, rd_addr} < LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_ok ? regs[rd_addr] : '0;

endmodule

// File: rtl/bus_reg_slave.sv
// Register slave: IDLE/RESP handshake FSM plus response registers.
// Ports: clock, reset, bus (slave modport), txn_count.
// Macro BUS_REG_SLAVE_ERR_EN flags accesses with addr >= DEPTH.
module bus_reg_slave
    import bus_reg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    bus_reg_slave_if.slave   bus,
    output logic [CNT_W-1:0] txn_count
);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              done;
    logic              err_n;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    bus_reg_file #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_file (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept && bus.req_write),
        .wr_addr (bus.req_addr),
        .wr_data (bus.req_wdata),
        .rd_addr (bus.req_addr),
        .rd_data (rd_data)
    );

`ifdef BUS_REG_SLAVE_ERR_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    assign err_n = ({1'b0, bus.req_addr} >= LIMIT);
`else
    assign err_n = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    // Response fields load only on accept, so they hold through RESP.
    // Write responses and out-of-range reads carry zero data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q   <= '0;
            err_q     <= 1'b0;
            txn_count <= '0;
        end else begin
            if (accept) begin
                rdata_q <= bus.req_write ? '0 : rd_data;
                err_q   <= err_n;
            end
            if (done) begin
                txn_count <= txn_count + 1'b1;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Directed bench for bus_reg_slave (ADDR_W=4, DATA_W=4, DEPTH=12).
// Inputs change and outputs are sampled on the falling edge.
module tb_bus_reg_slave;

`ifdef BUS_REG_SLAVE_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] txn_count;
    int         errors;
    int         checks;
    logic [3:0] model [12];
    logic [3:0] rd;
    logic       er;

    bus_reg_slave_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    bus_reg_slave #(
        .ADDR_W (4),
        .DATA_W (4),
        .DEPTH  (12)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .txn_count (txn_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one transaction from IDLE with rsp_ready=1.
    // Starts and ends on a falling edge with the slave in IDLE.
    task automatic txn(input logic w, input logic [3:0] a,
                       input logic [3:0] d,
                       output logic [3:0] rdata, output logic err);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.req_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 12; i++) model[i] = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 4'h0 ||
            bus.rsp_err !== 1'b0 || txn_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rdata=%h err=%b cnt=%0d, want 0 0 0 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, txn_count);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b want 1", bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        txn(1'b1, 4'd3, 4'hC, rd, er);
        model[3] = 4'hC;
        checks++;
        if (rd !== 4'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL wr3_rsp: rdata=%h err=%b want 0 0", rd, er);
        end
        txn(1'b0, 4'd3, 4'h0, rd, er);
        checks++;
        if (rd !== 4'hC || er !== 1'b0) begin
            errors++;
            $display("FAIL rd3_rsp: rdata=%h err=%b want c 0", rd, er);
        end
        checks++;
        if (txn_count !== 8'd2) begin
            errors++;
            $display("FAIL wr_rd_count: cnt=%0d want 2", txn_count);
        end
    endtask

    task automatic test_stall();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 4'd5;
        bus.req_wdata = 4'h6;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        model[5] = 4'h6;
        // A request presented while busy must not be taken.
        bus.req_addr  = 4'd7;
        bus.req_wdata = 4'hF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                txn_count !== 8'd2) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b ready=%b cnt=%0d want 1 0 2",
                         i, bus.rsp_valid, bus.req_ready, txn_count);
            end
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            txn_count !== 8'd3) begin
            errors++;
            $display("FAIL stall_release: ready=%b valid=%b cnt=%0d want 1 0 3",
                     bus.req_ready, bus.rsp_valid, txn_count);
        end
        // Read 5 under stall: data stays put while the address moves.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd5;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_addr  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.rsp_rdata !== 4'h6 || bus.rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL rd_stable[%0d]: rdata=%h err=%b want 6 0",
                         i, bus.rsp_rdata, bus.rsp_err);
            end
            @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (txn_count !== 8'd4) begin
            errors++;
            $display("FAIL stall_count: cnt=%0d want 4", txn_count);
        end
    endtask

    task automatic test_range();
        txn(1'b1, 4'd13, 4'h7, rd, er);
        checks++;
        if (rd !== 4'h0 || er !== EXP_ERR) begin
            errors++;
            $display("FAIL wr13: rdata=%h err=%b want 0 %b", rd, er, EXP_ERR);
        end
        txn(1'b0, 4'd13, 4'h0, rd, er);
        checks++;
        if (rd !== 4'h0 || er !== EXP_ERR) begin
            errors++;
            $display("FAIL rd13: rdata=%h err=%b want 0 %b", rd, er, EXP_ERR);
        end
        txn(1'b1, 4'd15, 4'h9, rd, er);
        txn(1'b0, 4'd15, 4'h0, rd, er);
        checks++;
        if (rd !== 4'h0 || er !== EXP_ERR) begin
            errors++;
            $display("FAIL rd15: rdata=%h err=%b want 0 %b", rd, er, EXP_ERR);
        end
        for (int i = 0; i < 12; i++) begin
            txn(1'b0, 4'(i), 4'h0, rd, er);
            checks++;
            if (rd !== model[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL reg_scan[%0d]: rdata=%h err=%b want %h 0",
                         i, rd, er, model[i]);
            end
        end
        checks++;
        if (txn_count !== 8'd20) begin
            errors++;
            $display("FAIL range_count: cnt=%0d want 20", txn_count);
        end
    endtask

    task automatic test_reset_mid_resp();
        txn(1'b1, 4'd2, 4'hA, rd, er);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd2;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 4'hA) begin
            errors++;
            $display("FAIL pre_reset: valid=%b rdata=%h want 1 a",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || txn_count !== 8'd0 ||
            bus.rsp_rdata !== 4'h0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b cnt=%0d rdata=%h ready=%b want 0 0 0 1",
                     bus.rsp_valid, txn_count, bus.rsp_rdata, bus.req_ready);
        end
        for (int i = 0; i < 12; i++) model[i] = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        txn(1'b0, 4'd2, 4'h0, rd, er);
        checks++;
        if (rd !== 4'h0 || txn_count !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_rd: rdata=%h cnt=%0d want 0 1", rd, txn_count);
        end
    endtask

    task automatic test_back_to_back();
        int   accepts;
        int   samples;
        int   alt_err;
        logic prev;
        test_reset();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'd0;
        bus.rsp_ready = 1'b1;
        accepts = 0;
        samples = 0;
        alt_err = 0;
        prev    = 1'b0;
        while (accepts < 257 && samples < 600) begin
            if (bus.req_ready === 1'b1) accepts++;
            if (bus.req_ready === prev) alt_err++;
            prev = bus.req_ready;
            samples++;
            if (accepts < 257) @(negedge clock);
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (accepts !== 257) begin
            errors++;
            $display("FAIL b2b_timeout: accepts=%0d want 257", accepts);
        end
        checks++;
        if (alt_err !== 0 || samples !== 513) begin
            errors++;
            $display("FAIL b2b_spacing: breaks=%0d cycles=%0d want 0 513",
                     alt_err, samples);
        end
        checks++;
        if (txn_count !== 8'd1) begin
            errors++;
            $display("FAIL b2b_wrap: cnt=%0d want 1", txn_count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_stall();
        test_range();
        test_reset_mid_resp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_reg_slave.md
BUS_REG_SLAVE -- requirements
Module: bus_reg_slave

Interface
- REQ-001 Parameter ADDR_W, default 4, request address width in bits.
- REQ-002 Parameter DATA_W, default 4, data width in bits.
- REQ-003 Parameter DEPTH, default 12, number of implemented registers; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
- REQ-004 clock  input  1  single clock; all state updates on rising edge.
- REQ-005 reset  input  1  asynchronous, active-high reset.
- REQ-006 req_valid  input  1  request present.
- REQ-007 req_ready  output  1  slave can accept a request.
- REQ-008 req_write  input  1  1 = write, 0 = read.
- REQ-009 req_addr  input  ADDR_W  register index.
- REQ-010 req_wdata  input  DATA_W  write data.
- REQ-011 rsp_valid  output  1  response present.
- REQ-012 rsp_ready  input  1  master accepts the response.
- REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes.
- REQ-014 rsp_err  output  1  access error flag.
- REQ-015 txn_count  output  8  number of completed responses, modulo 256.

Function
- REQ-016 The FSM SHALL have exactly two states: IDLE and RESP.
- REQ-017 req_ready SHALL be 1 in IDLE and 0 in RESP; rsp_valid SHALL be 1 in RESP and 0 in IDLE.
- REQ-018 A request is accepted in a cycle where req_valid && req_ready; the FSM SHALL then go IDLE->RESP on that edge.
- REQ-019 An accepted in-range write SHALL update register[req_addr] with req_wdata on the accepting edge.
- REQ-020 An accepted in-range read SHALL capture register[req_addr] into rsp_rdata on the accepting edge, giving 1-cycle latency.
- REQ-021 In RESP, rsp_rdata and rsp_err SHALL stay stable until rsp_valid && rsp_ready.
- REQ-022 In RESP with rsp_ready=1, the FSM SHALL go to IDLE and txn_count SHALL increment by 1, wrapping from 255 to 0.
- REQ-023 Minimum request spacing SHALL be 2 cycles; there is no back-to-back acceptance.
- REQ-024 A read and a write to the same address SHALL be ordered by acceptance, so a read accepted after a write returns the written data.
- REQ-025 In IDLE, req_write, req_addr and req_wdata SHALL be ignored unless req_valid=1.

Reset
- REQ-026 On reset assertion, regardless of the clock: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_count=0, and all registers=0.
- REQ-027 Reset asserted during RESP SHALL drop the pending response without incrementing txn_count.
- REQ-028 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
- REQ-029 Macro BUS_REG_SLAVE_ERR_EN, when defined, makes an access with req_addr >= DEPTH an error.
  - Error write: register array unchanged, rsp_err=1.
  - Error read: rsp_rdata=0, rsp_err=1.
- REQ-030 Without BUS_REG_SLAVE_ERR_EN:
  - rsp_err is tied to 0.
  - Out-of-range writes are silently dropped.
  - Out-of-range reads return 0.
  - The handshake is identical to the defined case.

Structure
- REQ-031 Package bus_reg_pkg SHALL hold:
  - the state enum {IDLE, RESP};
  - default ADDR_W, DATA_W and DEPTH constants;
  - the txn_count width constant (8).
- REQ-032 Storage SHALL be a sub-module bus_reg_file with one write port and one read port, both combinational-address and synchronous-write; bus_reg_slave holds the FSM and response registers.

Verification
- REQ-033 Reset then write addr 3 data 0xC, then read addr 3 -> rsp_rdata=0xC, rsp_err=0, txn_count=2.
- REQ-034 Write addr 5 with rsp_ready held 0 for 4 cycles -> rsp_valid stays 1, req_ready stays 0, txn_count unchanged; then rsp_ready=1 -> IDLE next cycle.
- REQ-035 With BUS_REG_SLAVE_ERR_EN, write addr 13 data 0x7 then read 13 -> both responses have rsp_err=1, read rsp_rdata=0, registers 0..11 unchanged; without the macro, rsp_err=0 on both.
- REQ-036 Issue 257 back-to-back transactions with rsp_ready=1 -> txn_count=1, and accepts occur every 2nd cycle.
- REQ-037 Assert reset mid-RESP after a read of a register holding 0xA -> rsp_valid=0 immediately, txn_count=0, and a subsequent read of the same address returns 0.
